// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: merges two branch-resolution ports into one BPU update bundle,
// issuing oldest-first flush redirects and FIFO-buffered BTB/LPHT training writes.
module bpu_update_ctrl #(
   parameter int FIFO_DEPTH      = 4,
   parameter int LPHT_ADDR_WIDTH = 8,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       r0_valid,
   input  logic [29:0]                r0_pc,
   input  logic [29:0]                r0_target,
   input  logic [1:0]                 r0_br_type,
   input  logic                       r0_taken,
   input  logic [1:0]                 r0_lphr,
   input  logic [LPHT_ADDR_WIDTH-1:0] r0_lphr_index,
   input  logic                       r0_mispredict,
   input  logic                       r1_valid,
   input  logic [29:0]                r1_pc,
   input  logic [29:0]                r1_target,
   input  logic [1:0]                 r1_br_type,
   input  logic                       r1_taken,
   input  logic [1:0]                 r1_lphr,
   input  logic [LPHT_ADDR_WIDTH-1:0] r1_lphr_index,
   input  logic                       r1_mispredict,
   output logic                       upd_flush,
   output logic                       upd_btb_update,
   output logic                       upd_lpht_update,
   output logic [29:0]                upd_pc,
   output logic [29:0]                upd_br_target,
   output logic [1:0]                 upd_br_type,
   output logic                       upd_br_taken,
   output logic [1:0]                 upd_lphr,
   output logic [LPHT_ADDR_WIDTH-1:0] upd_lphr_index,
   output logic [CNT_WIDTH-1:0]       drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   typedef struct packed {
      logic [29:0]                pc;
      logic [29:0]                tgt;
      logic [1:0]                 typ;
      logic                       tkn;
      logic [1:0]                 lphr;
      logic [LPHT_ADDR_WIDTH-1:0] idx;
   } ent_t;
   ent_t                 r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_rptr, r_wptr;
   logic [LW-1:0]        r_level;
   logic [CNT_WIDTH-1:0] r_drop;
   logic                 r_flush;
   logic [29:0]          r_flush_tgt;
   logic                 w_live0, w_live1, w_mis0, w_mis1, w_ent0, w_ent1;
   logic                 w_pop, w_fit0, w_fit1;
   logic [LW:0]          w_free;
   logic [1:0]           w_npush, w_ndrop;
   logic [CNT_WIDTH:0]   w_drop_sum;
   ent_t                 w_e0, w_e1, w_head;
   always_comb begin
      w_live0    = r0_valid && !r_flush;
      w_live1    = r1_valid && !r_flush && !(w_live0 && r0_mispredict);
      w_mis0     = w_live0 && r0_mispredict;
      w_mis1     = w_live1 && r1_mispredict;
      w_ent0     = w_live0 && (r0_br_type == 2'd0 || r0_taken);
      w_ent1     = w_live1 && (r1_br_type == 2'd0 || r1_taken);
      w_e0       = '{r0_pc, r0_target, r0_br_type, r0_taken, r0_lphr, r0_lphr_index};
      w_e1       = '{r1_pc, r1_target, r1_br_type, r1_taken, r1_lphr, r1_lphr_index};
      w_head     = r_mem[r_rptr];
      w_pop      = (r_level != '0) && !r_flush;
      // free slots include the one released by this cycle's pop
      w_free     = (LW+1)'(FIFO_DEPTH) - {1'b0, r_level} + (LW+1)'(w_pop);
      w_fit0     = w_ent0 && (w_free != '0);
      w_fit1     = w_ent1 && (w_free > (LW+1)'(w_ent0));
      w_npush    = {1'b0, w_fit0} + {1'b0, w_fit1};
      w_ndrop    = {1'b0, w_ent0 && !w_fit0} + {1'b0, w_ent1 && !w_fit1};
      w_drop_sum = {1'b0, r_drop} + (CNT_WIDTH+1)'(w_ndrop);
   end
   always_ff @(posedge clk) begin
      if (w_fit0) r_mem[r_wptr] <= w_e0;
      if (w_fit1) r_mem[w_fit0 ? r_wptr + AW'(1) : r_wptr] <= w_e1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rptr      <= '0;
         r_wptr      <= '0;
         r_level     <= '0;
         r_drop      <= '0;
         r_flush     <= 1'b0;
         r_flush_tgt <= '0;
      end else begin
         r_rptr      <= r_rptr + AW'(w_pop);
         r_wptr      <= r_wptr + AW'(w_npush);
         r_level     <= r_level + LW'(w_npush) - LW'(w_pop);
         r_drop      <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
         r_flush     <= w_mis0 || w_mis1;
         r_flush_tgt <= w_mis0 ? r0_target : r1_target;
      end
   end
   always_comb begin
      upd_flush       = r_flush;
      upd_btb_update  = w_pop && w_head.tkn;
      upd_lpht_update = w_pop && (w_head.typ == 2'd0);
      upd_pc          = w_pop ? w_head.pc : '0;
      upd_br_target   = r_flush ? r_flush_tgt : (w_pop ? w_head.tgt : '0);
      upd_br_type     = w_pop ? w_head.typ : '0;
      upd_br_taken    = w_pop && w_head.tkn;
      upd_lphr        = w_pop ? w_head.lphr : '0;
      upd_lphr_index  = w_pop ? w_head.idx : '0;
      drop_cnt        = r_drop;
      fifo_level      = r_level;
   end
endmodule
